// File: rtl/waveform_player_sdram_if.sv
// Bus bundle for the waveform player: CPU register port, SDRAM master port
// and the two audio sample streams.
// master = the player's view (drives SDRAM requests and audio samples);
// slave  = the environment's view (CPU, SDRAM controller, audio FIFOs).
interface waveform_player_sdram_if;
  // CPU register port
  logic        address;
  logic        write;
  logic [31:0] writedata;
  // Audio streams
  logic        l_audio_ready;
  logic        r_audio_ready;
  logic [15:0] l_audio_data;
  logic [15:0] r_audio_data;
  logic        l_audio_valid;
  logic        r_audio_valid;
  // SDRAM master port
  logic [25:0] sdram_addr;
  logic [1:0]  sdram_byteenable_n;
  logic        sdram_chipselect;
  logic [15:0] sdram_writedata;
  logic        sdram_read_n;
  logic        sdram_write_n;
  logic [15:0] sdram_readdata;
  logic        sdram_readdata_valid;
  logic        sdram_waitrequest;

  modport master (
    input  address, write, writedata,
    input  l_audio_ready, r_audio_ready,
    input  sdram_readdata, sdram_readdata_valid, sdram_waitrequest,
    output l_audio_data, r_audio_data, l_audio_valid, r_audio_valid,
    output sdram_addr, sdram_byteenable_n, sdram_chipselect,
    output sdram_writedata, sdram_read_n, sdram_write_n
  );

  modport slave (
    output address, write, writedata,
    output l_audio_ready, r_audio_ready,
    output sdram_readdata, sdram_readdata_valid, sdram_waitrequest,
    input  l_audio_data, r_audio_data, l_audio_valid, r_audio_valid,
    input  sdram_addr, sdram_byteenable_n, sdram_chipselect,
    input  sdram_writedata, sdram_read_n, sdram_write_n
  );
endinterface

// File: rtl/waveform_player_sdram.sv
// Purpose: loops over SDRAM words 0..max_audio_index, presenting each 16-bit
//   sample on both left and right valid/ready streams; CPU sets LENGTH/CONTROL.
// Latency: request issued the cycle after enable; sample valid the cycle after
//   readdata_valid. Backpressure: one read outstanding; next read waits until
//   both channels have handshaked the current sample.
// Ports: clock, reset_n (sync, active-low); bus = waveform_player_sdram_if.master.
module waveform_player_sdram (
  input  logic                          clock,
  input  logic                          reset_n,
  waveform_player_sdram_if.master       bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_PRESENT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [25:0] max_idx_q;
  logic        enable_q;
  logic [25:0] index_q, index_d;
  logic [25:0] addr_q, addr_d;
  logic        cs_q, cs_d;
  logic        rd_n_q, rd_n_d;
  logic [15:0] data_q, data_d;
  logic        l_vld_q, l_vld_d;
  logic        r_vld_q, r_vld_d;

  logic        both_clear;
  logic [25:0] index_next;
  logic        unused_wdata;

  assign both_clear   = ~l_vld_q & ~r_vld_q;
  // >= rather than == so a LENGTH shrunk below the current index still wraps.
  assign index_next   = (index_q >= max_idx_q) ? 26'd0 : index_q + 26'd1;
  assign unused_wdata = ^bus.writedata[31:26];

  // Write-only configuration registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      max_idx_q <= '0;
      enable_q  <= 1'b0;
    end else if (bus.write) begin
      if (bus.address == 1'b0) max_idx_q <= bus.writedata[25:0];
      else                     enable_q  <= bus.writedata[0];
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic. A stop never aborts a read already issued: REQ and WAIT
  // run to completion and WAIT then drops the data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (enable_q) state_d = S_REQ;
      S_REQ:     if (!bus.sdram_waitrequest) state_d = S_WAIT;
      S_WAIT:    if (bus.sdram_readdata_valid) state_d = enable_q ? S_PRESENT : S_IDLE;
      S_PRESENT: begin
        if (!enable_q)       state_d = S_IDLE;
        else if (both_clear) state_d = S_REQ;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-state logic.
  always_comb begin
    index_d = index_q;
    data_d  = data_q;
    l_vld_d = l_vld_q;
    r_vld_d = r_vld_q;
    case (state_q)
      S_IDLE: index_d = '0;
      S_WAIT: begin
        if (bus.sdram_readdata_valid && enable_q) begin
          data_d  = bus.sdram_readdata;
          l_vld_d = 1'b1;
          r_vld_d = 1'b1;
        end
      end
      S_PRESENT: begin
        if (!enable_q) begin
          l_vld_d = 1'b0;
          r_vld_d = 1'b0;
          index_d = '0;
        end else if (both_clear) begin
          index_d = index_next;
        end else begin
          if (bus.l_audio_ready) l_vld_d = 1'b0;
          if (bus.r_audio_ready) r_vld_d = 1'b0;
        end
      end
      default: ;
    endcase
    // Request lines are registered from the next state so they are clean flops
    // and hold steady for the whole waitrequest stall.
    cs_d   = (state_d == S_REQ);
    rd_n_d = ~cs_d;
    addr_d = ((state_d == S_REQ) && (state_q != S_REQ)) ? index_d : addr_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      index_q <= '0;
      addr_q  <= '0;
      cs_q    <= 1'b0;
      rd_n_q  <= 1'b1;
      data_q  <= '0;
      l_vld_q <= 1'b0;
      r_vld_q <= 1'b0;
    end else begin
      index_q <= index_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      rd_n_q  <= rd_n_d;
      data_q  <= data_d;
      l_vld_q <= l_vld_d;
      r_vld_q <= r_vld_d;
    end
  end

  assign bus.l_audio_data       = data_q;
  assign bus.r_audio_data       = data_q;
  assign bus.l_audio_valid      = l_vld_q;
  assign bus.r_audio_valid      = r_vld_q;
  assign bus.sdram_addr         = addr_q;
  assign bus.sdram_chipselect   = cs_q;
  assign bus.sdram_read_n       = rd_n_q;
  assign bus.sdram_byteenable_n = 2'b00;
  assign bus.sdram_writedata    = 16'h0000;
  assign bus.sdram_write_n      = 1'b1;

endmodule

// File: tb/tb_waveform_player_sdram.sv
// Bench for waveform_player_sdram: SDRAM responder model with programmable
// stall/latency, per-channel expected-sample queues, and an address model.
module tb_waveform_player_sdram;

  logic clock;
  logic reset_n;

  waveform_player_sdram_if bus();

  waveform_player_sdram dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_stall = 0;
  int          rd_lat   = 2;
  logic        en_model = 1'b0;
  logic [25:0] exp_max  = '0;
  logic [25:0] exp_addr = '0;
  logic        outstanding = 1'b0;
  int          lat_left = 0;
  int          stall_left = -1;
  logic [25:0] pend_addr = '0;
  logic [15:0] lq[$];
  logic [15:0] rq[$];
  logic [25:0] req_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sample_of(input logic [25:0] a);
    logic [15:0] s;
    s = (a == 26'd0) ? 16'h1234 : (16'hA500 ^ a[15:0]);
    return s;
  endfunction

  // SDRAM responder: stalls each request wr_stall cycles, returns data rd_lat
  // cycles after acceptance, checks request addresses against the model.
  initial begin
    bus.sdram_waitrequest    = 1'b1;
    bus.sdram_readdata_valid = 1'b0;
    bus.sdram_readdata       = '0;
    forever begin
      @(negedge clock);
      bus.sdram_readdata_valid = 1'b0;
      bus.sdram_waitrequest    = 1'b1;
      if (!reset_n) begin
        outstanding = 1'b0;
        stall_left  = -1;
      end else if (outstanding) begin
        lat_left--;
        if (lat_left <= 0) begin
          bus.sdram_readdata_valid = 1'b1;
          bus.sdram_readdata       = sample_of(pend_addr);
          if (en_model) begin
            lq.push_back(sample_of(pend_addr));
            rq.push_back(sample_of(pend_addr));
          end
          outstanding = 1'b0;
        end
      end else if (bus.sdram_chipselect && !bus.sdram_read_n) begin
        if (stall_left < 0) stall_left = wr_stall;
        if (stall_left > 0) begin
          stall_left--;
          check("req_hold_addr", bus.sdram_addr, exp_addr);
        end else begin
          bus.sdram_waitrequest = 1'b0;
          check("req_addr", bus.sdram_addr, exp_addr);
          req_log.push_back(bus.sdram_addr);
          pend_addr   = bus.sdram_addr;
          exp_addr    = (exp_addr >= exp_max) ? 26'd0 : exp_addr + 26'd1;
          outstanding = 1'b1;
          lat_left    = rd_lat;
          stall_left  = -1;
        end
      end else if (!en_model) begin
        exp_addr = '0;
      end
    end
  end

  // Consumer monitor: every handshake pops that channel's expected sample.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n && bus.l_audio_valid && bus.l_audio_ready) begin
        if (lq.size() == 0) check("l_unexpected_sample", bus.l_audio_data, 32'hFFFF_FFFF);
        else                check("l_data", bus.l_audio_data, lq.pop_front());
      end
      if (reset_n && bus.r_audio_valid && bus.r_audio_ready) begin
        if (rq.size() == 0) check("r_unexpected_sample", bus.r_audio_data, 32'hFFFF_FFFF);
        else                check("r_data", bus.r_audio_data, rq.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic reg_write(input logic a, input logic [31:0] d);
    @(posedge clock); #1;
    bus.address   = a;
    bus.write     = 1'b1;
    bus.writedata = d;
    if (a == 1'b0) exp_max  = d[25:0];
    else           en_model = d[0];
    @(posedge clock); #1;
    bus.write = 1'b0;
  endtask

  // Stops the player while a read is outstanding (WAIT) and checks it idles.
  task automatic stop_in_wait(input string tag);
    rd_lat = 6;
    for (int i = 0; i < 200 && outstanding; i++) begin @(posedge clock); #1; end
    for (int i = 0; i < 200 && !outstanding; i++) begin @(posedge clock); #1; end
    check({tag, "_reached_wait"}, outstanding, 1'b1);
    reg_write(1'b1, 32'd0);
    for (int i = 0; i < 50 && outstanding; i++) begin @(posedge clock); #1; end
    repeat (4) @(negedge clock);
    check({tag, "_l_valid"}, bus.l_audio_valid, 1'b0);
    check({tag, "_r_valid"}, bus.r_audio_valid, 1'b0);
    check({tag, "_cs"}, bus.sdram_chipselect, 1'b0);
    check({tag, "_read_n"}, bus.sdram_read_n, 1'b1);
    check({tag, "_lq_empty"}, lq.size(), 0);
    rd_lat = 2;
  endtask

  int base;

  initial begin
    reset_n           = 1'b0;
    bus.address       = 1'b0;
    bus.write         = 1'b0;
    bus.writedata     = '0;
    bus.l_audio_ready = 1'b0;
    bus.r_audio_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_l_data", bus.l_audio_data, 16'h0);
    check("rst_r_data", bus.r_audio_data, 16'h0);
    check("rst_l_valid", bus.l_audio_valid, 1'b0);
    check("rst_r_valid", bus.r_audio_valid, 1'b0);
    check("rst_addr", bus.sdram_addr, 26'h0);
    check("rst_cs", bus.sdram_chipselect, 1'b0);
    check("rst_read_n", bus.sdram_read_n, 1'b1);
    check("rst_write_n", bus.sdram_write_n, 1'b1);
    check("rst_be_n", bus.sdram_byteenable_n, 2'b00);
    check("rst_wdata", bus.sdram_writedata, 16'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Configure LENGTH = 15; nothing may be requested yet.
    reg_write(1'b0, 32'hF);
    repeat (3) begin
      @(negedge clock);
      check("cfg_no_read", bus.sdram_read_n, 1'b1);
    end

    // Start with a 3-cycle waitrequest stall.
    wr_stall = 3;
    reg_write(1'b1, 32'd1);
    @(negedge clock);
    check("start_not_early", bus.sdram_read_n, 1'b1);
    repeat (3) begin
      @(negedge clock);
      check("stall_read_n", bus.sdram_read_n, 1'b0);
      check("stall_cs", bus.sdram_chipselect, 1'b1);
      check("stall_addr", bus.sdram_addr, 26'd0);
    end
    for (int i = 0; i < 50 && !bus.l_audio_valid; i++) @(negedge clock);
    check("first_l_valid", bus.l_audio_valid, 1'b1);
    check("first_r_valid", bus.r_audio_valid, 1'b1);
    check("first_l_data", bus.l_audio_data, 16'h1234);
    check("first_r_data", bus.r_audio_data, 16'h1234);

    // Backpressure: only left consumes.
    @(posedge clock); #1;
    bus.l_audio_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("bp_l_valid", bus.l_audio_valid, 1'b0);
    check("bp_r_valid", bus.r_audio_valid, 1'b1);
    check("bp_no_req", bus.sdram_chipselect, 1'b0);
    wr_stall = 1;
    @(posedge clock); #1;
    bus.r_audio_ready = 1'b1;
    for (int i = 0; i < 50 && !bus.sdram_chipselect; i++) @(negedge clock);
    check("bp_next_cs", bus.sdram_chipselect, 1'b1);
    check("bp_next_addr", bus.sdram_addr, 26'd1);

    // Wrap with random backpressure.
    for (int i = 0; i < 5000 && req_log.size() < 18; i++) begin
      @(posedge clock); #1;
      bus.l_audio_ready = 1'($urandom_range(0, 1));
      bus.r_audio_ready = 1'($urandom_range(0, 1));
    end
    check("wrap_req_count_reached", (req_log.size() >= 18), 1'b1);
    if (req_log.size() >= 18) begin
      check("wrap_req16_is_max", req_log[15], 26'd15);
      check("wrap_req17_is_zero", req_log[16], 26'd0);
    end
    bus.l_audio_ready = 1'b1;
    bus.r_audio_ready = 1'b1;

    stop_in_wait("stop1");

    // Restart begins again from sample 0.
    base = req_log.size();
    reg_write(1'b1, 32'd1);
    for (int i = 0; i < 500 && req_log.size() < base + 3; i++) @(negedge clock);
    check("restart_req_count", (req_log.size() >= base + 3), 1'b1);
    if (req_log.size() >= base + 3) begin
      check("restart_addr0", req_log[base], 26'd0);
      check("restart_addr1", req_log[base + 1], 26'd1);
    end
    stop_in_wait("stop2");

    // LENGTH = 0 replays sample 0.
    reg_write(1'b0, 32'd0);
    base = req_log.size();
    reg_write(1'b1, 32'd1);
    for (int i = 0; i < 500 && req_log.size() < base + 4; i++) @(negedge clock);
    check("max0_req_count", (req_log.size() >= base + 4), 1'b1);
    if (req_log.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) check("max0_addr", req_log[base + k], 26'd0);
    end
    stop_in_wait("stop3");
    check("final_rq_empty", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
